// File: rtl/uart_rx_cmd_parser.sv
// Host->FPGA command deframer: HEADER, CMD, [CNT], THETA, CRC-8 frames to CORDIC/uart_tx_msg strobes.
// Latency: cmd_vld_o 1 cycle after CRC byte strobe, burst/theta strobes 1 cycle after that; errors 1 cycle after cause.
// Backpressure: none; bytes are strobes from uart_rx, bytes arriving while committing are dropped.
module uart_rx_cmd_parser #(
  parameter logic [7:0] CRC_POLY         = 8'h07,
  parameter int         THETA_W          = 48,
  parameter int         TIMEOUT_CYC      = 1_000_000,
  parameter logic [7:0] BYTE_HEADER      = 8'hA5,
  parameter logic [7:0] CMD_SINGLE_TRANS = 8'h01,
  parameter logic [7:0] CMD_BURST_TRANS  = 8'h02
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [7:0]         rxd_byte_i,
  input  logic               rxd_byte_vld_i,
  input  logic               rxd_frame_err_i,
  output logic [7:0]         cmd_reg_o,
  output logic               cmd_vld_o,
  output logic [7:0]         burst_cnt_o,
  output logic               burst_cnt_vld_o,
  output logic [THETA_W-1:0] theta_o,
  output logic               theta_vld_o,
  output logic               rxd_msg_err_o
);

  localparam int NB    = THETA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_HDR, S_CMD, S_CNT, S_THETA, S_CRC, S_COMMIT, S_COMMIT2
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         crc, crc_d;
  logic [7:0]         cmd_sh;
  logic [7:0]         cnt_sh, cnt_d;
  logic [THETA_W-1:0] theta_sh;
  logic [IDX_W-1:0]   byte_idx, idx_d;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               in_frame, tmo_hit;
  logic               err_nxt, cmd_we, theta_we, cmd_ld;

  function automatic logic [7:0] crc_upd(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign in_frame = (state == S_CMD) || (state == S_CNT) ||
                    (state == S_THETA) || (state == S_CRC);
  assign tmo_hit  = in_frame && (tmo_cnt == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_HDR;
    else         state <= state_nxt;
  end

  // Abort sources are checked ahead of the byte, so each abort yields exactly one err pulse.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    crc_d     = crc;
    cnt_d     = cnt_sh;
    idx_d     = byte_idx;
    cmd_we    = 1'b0;
    theta_we  = 1'b0;
    cmd_ld    = 1'b0;
    if (in_frame && rxd_frame_err_i) begin
      err_nxt   = 1'b1;
      state_nxt = S_HDR;
    end else if (tmo_hit) begin
      err_nxt   = 1'b1;
      state_nxt = S_HDR;
    end else begin
      case (state)
        S_HDR: begin
          if (rxd_byte_vld_i && rxd_byte_i == BYTE_HEADER) begin
            crc_d     = crc_upd(8'h00, rxd_byte_i);
            state_nxt = S_CMD;
          end
        end
        S_CMD: begin
          if (rxd_byte_vld_i) begin
            crc_d  = crc_upd(crc, rxd_byte_i);
            idx_d  = '0;
            cmd_we = 1'b1;
            if (rxd_byte_i == CMD_SINGLE_TRANS) begin
              cnt_d     = 8'd1;
              state_nxt = S_THETA;
            end else if (rxd_byte_i == CMD_BURST_TRANS) begin
              state_nxt = S_CNT;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = S_HDR;
            end
          end
        end
        S_CNT: begin
          if (rxd_byte_vld_i) begin
            if (rxd_byte_i == 8'h00) begin
              err_nxt   = 1'b1;
              state_nxt = S_HDR;
            end else begin
              crc_d     = crc_upd(crc, rxd_byte_i);
              cnt_d     = rxd_byte_i;
              state_nxt = S_THETA;
            end
          end
        end
        S_THETA: begin
          if (rxd_byte_vld_i) begin
            crc_d    = crc_upd(crc, rxd_byte_i);
            theta_we = 1'b1;
            if (byte_idx == IDX_W'(NB - 1)) state_nxt = S_CRC;
            else                            idx_d     = byte_idx + IDX_W'(1);
          end
        end
        S_CRC: begin
          if (rxd_byte_vld_i) begin
            if (rxd_byte_i == crc) begin
              cmd_ld    = 1'b1;
              state_nxt = S_COMMIT;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = S_HDR;
            end
          end
        end
        S_COMMIT:  state_nxt = S_COMMIT2;
        S_COMMIT2: state_nxt = S_HDR;
        default:   state_nxt = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (!in_frame || rxd_byte_vld_i) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc      <= 8'h00;
      cmd_sh   <= 8'h00;
      cnt_sh   <= 8'h00;
      theta_sh <= '0;
      byte_idx <= '0;
    end else begin
      crc      <= crc_d;
      cnt_sh   <= cnt_d;
      byte_idx <= idx_d;
      if (cmd_we) cmd_sh <= rxd_byte_i;
      if (theta_we) begin
        for (int i = 0; i < NB; i++) begin
          if (byte_idx == IDX_W'(i)) theta_sh[i*8 +: 8] <= rxd_byte_i;
        end
      end
    end
  end

  // Command is published with cmd_vld; count/theta a cycle later, as uart_tx_msg expects.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_reg_o     <= 8'h00;
      burst_cnt_o   <= 8'h00;
      theta_o       <= '0;
      rxd_msg_err_o <= 1'b0;
    end else begin
      rxd_msg_err_o <= err_nxt;
      if (cmd_ld) cmd_reg_o <= cmd_sh;
      if (state == S_COMMIT) begin
        burst_cnt_o <= cnt_sh;
        theta_o     <= theta_sh;
      end
    end
  end

  assign cmd_vld_o       = (state == S_COMMIT);
  assign burst_cnt_vld_o = (state == S_COMMIT2);
  assign theta_vld_o     = (state == S_COMMIT2);

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed bench for uart_rx_cmd_parser: table of frames plus timeout, frame-error and reset sequences.
module tb_uart_rx_cmd_parser;
  localparam int         THETA_W = 48;
  localparam int         TMO     = 200;
  localparam logic [7:0] HDR     = 8'hA5;
  localparam logic [7:0] C_S     = 8'h01;
  localparam logic [7:0] C_B     = 8'h02;
  localparam logic [7:0] POLY    = 8'h07;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic [7:0]         rxd_byte_i = 8'h00;
  logic               rxd_byte_vld_i = 1'b0;
  logic               rxd_frame_err_i = 1'b0;
  logic [7:0]         cmd_reg_o;
  logic               cmd_vld_o;
  logic [7:0]         burst_cnt_o;
  logic               burst_cnt_vld_o;
  logic [THETA_W-1:0] theta_o;
  logic               theta_vld_o;
  logic               rxd_msg_err_o;

  uart_rx_cmd_parser #(
    .CRC_POLY(POLY), .THETA_W(THETA_W), .TIMEOUT_CYC(TMO),
    .BYTE_HEADER(HDR), .CMD_SINGLE_TRANS(C_S), .CMD_BURST_TRANS(C_B)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rxd_byte_i(rxd_byte_i), .rxd_byte_vld_i(rxd_byte_vld_i), .rxd_frame_err_i(rxd_frame_err_i),
    .cmd_reg_o(cmd_reg_o), .cmd_vld_o(cmd_vld_o),
    .burst_cnt_o(burst_cnt_o), .burst_cnt_vld_o(burst_cnt_vld_o),
    .theta_o(theta_o), .theta_vld_o(theta_vld_o), .rxd_msg_err_o(rxd_msg_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, byte_cyc = 0;
  int n_cmd = 0, n_bv = 0, n_tv = 0, n_err = 0;
  int cyc_cmd = 0, cyc_bv = 0, cyc_tv = 0, cyc_err = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Pulse monitor samples mid-cycle, well clear of both edges.
  always @(posedge clk_i) begin
    #3;
    if (cmd_vld_o)       begin n_cmd++; cyc_cmd = cyc; end
    if (burst_cnt_vld_o) begin n_bv++;  cyc_bv  = cyc; end
    if (theta_vld_o)     begin n_tv++;  cyc_tv  = cyc; end
    if (rxd_msg_err_o)   begin n_err++; cyc_err = cyc; end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ POLY) : {c[6:0], 1'b0};
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    rxd_byte_i     = b;
    rxd_byte_vld_i = 1'b1;
    byte_cyc       = cyc;
    @(negedge clk_i);
    rxd_byte_vld_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] cnt, input logic [47:0] th,
                            input logic [7:0] cx, input int nb);
    logic [7:0] q[$];
    logic [7:0] c;
    int         n;
    q.push_back(HDR);
    q.push_back(cmd);
    if (cmd == C_B) q.push_back(cnt);
    for (int k = 0; k < 6; k++) q.push_back(th[k*8 +: 8]);
    c = 8'h00;
    foreach (q[k]) c = crc8(c, q[k]);
    q.push_back(c ^ cx);
    n = (nb == 0) ? q.size() : nb;
    for (int k = 0; k < n; k++) send_byte(q[k]);
  endtask

  typedef struct {
    logic        pre_garb;
    logic [7:0]  cmd;
    logic [7:0]  cnt;
    logic [47:0] th;
    logic [7:0]  cx;
    int          nb;
    logic        ok;
    logic [7:0]  e_cmd;
    logic [7:0]  e_cnt;
    logic [47:0] e_th;
  } vec_t;

  vec_t tv[7];

  initial begin
    int c0, e0, t0, b0, bc;

    tv[0] = '{1'b0, C_S,   8'h00, 48'h0000_1234_5678, 8'h00, 0, 1'b1, C_S, 8'h01, 48'h0000_1234_5678};
    tv[1] = '{1'b0, C_B,   8'h05, 48'h0000_0000_ABCD, 8'h00, 0, 1'b1, C_B, 8'h05, 48'h0000_0000_ABCD};
    tv[2] = '{1'b0, C_S,   8'h00, 48'h1111_1111_1111, 8'h01, 0, 1'b0, C_B, 8'h05, 48'h0000_0000_ABCD};
    tv[3] = '{1'b1, C_S,   8'h00, 48'h00C0_FFEE_0001, 8'h00, 0, 1'b1, C_S, 8'h01, 48'h00C0_FFEE_0001};
    tv[4] = '{1'b0, 8'h7E, 8'h00, 48'h0,              8'h00, 2, 1'b0, C_S, 8'h01, 48'h00C0_FFEE_0001};
    tv[5] = '{1'b0, C_B,   8'h00, 48'h0,              8'h00, 3, 1'b0, C_S, 8'h01, 48'h00C0_FFEE_0001};
    tv[6] = '{1'b0, C_B,   8'hFF, 48'hFEDC_BA98_7654, 8'h00, 0, 1'b1, C_B, 8'hFF, 48'hFEDC_BA98_7654};

    repeat (3) @(negedge clk_i);
    chk("reset cmd_reg", cmd_reg_o, 0);
    chk("reset burst_cnt", burst_cnt_o, 0);
    chk("reset theta", theta_o, 0);
    chk("reset strobes", {cmd_vld_o, burst_cnt_vld_o, theta_vld_o, rxd_msg_err_o}, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 7; i++) begin
      c0 = n_cmd; e0 = n_err; t0 = n_tv; b0 = n_bv;
      if (tv[i].pre_garb) begin
        send_byte(8'h00);
        send_byte(8'hFF);
      end
      send_frame(tv[i].cmd, tv[i].cnt, tv[i].th, tv[i].cx, tv[i].nb);
      bc = byte_cyc;
      repeat (4) @(negedge clk_i);
      chk($sformatf("v%0d cmd_vld count", i), n_cmd - c0, tv[i].ok);
      chk($sformatf("v%0d err count", i), n_err - e0, !tv[i].ok);
      chk($sformatf("v%0d theta_vld count", i), n_tv - t0, tv[i].ok);
      chk($sformatf("v%0d burst_vld count", i), n_bv - b0, tv[i].ok);
      if (tv[i].ok) begin
        chk($sformatf("v%0d cmd_vld latency", i), cyc_cmd - bc, 1);
        chk($sformatf("v%0d burst_vld latency", i), cyc_bv - bc, 2);
        chk($sformatf("v%0d theta_vld latency", i), cyc_tv - bc, 2);
      end
      chk($sformatf("v%0d cmd_reg", i), cmd_reg_o, tv[i].e_cmd);
      chk($sformatf("v%0d burst_cnt", i), burst_cnt_o, tv[i].e_cnt);
      chk($sformatf("v%0d theta", i), theta_o, tv[i].e_th);
    end

    // Inter-byte timeout after three bytes, then recovery.
    e0 = n_err;
    send_byte(HDR);
    send_byte(C_S);
    send_byte(8'h11);
    bc = byte_cyc;
    repeat (TMO - 5) @(negedge clk_i);
    chk("timeout early err", n_err - e0, 0);
    repeat (20) @(negedge clk_i);
    chk("timeout err count", n_err - e0, 1);
    chk("timeout err timing", ((cyc_err - bc) >= TMO) && ((cyc_err - bc) <= TMO + 3), 1);
    c0 = n_cmd;
    send_frame(C_B, 8'h03, 48'h0102_0304_0506, 8'h00, 0);
    repeat (4) @(negedge clk_i);
    chk("post-timeout cmd_vld count", n_cmd - c0, 1);
    chk("post-timeout burst_cnt", burst_cnt_o, 8'h03);
    chk("post-timeout theta", theta_o, 48'h0102_0304_0506);

    // Stop-bit error: ignored while hunting for a header, aborts mid-theta.
    e0 = n_err;
    @(negedge clk_i); rxd_frame_err_i = 1'b1;
    @(negedge clk_i); rxd_frame_err_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("frame_err idle ignored", n_err - e0, 0);
    send_byte(HDR);
    send_byte(C_S);
    send_byte(8'h21);
    send_byte(8'h43);
    @(negedge clk_i); rxd_frame_err_i = 1'b1;
    @(negedge clk_i); rxd_frame_err_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("frame_err mid-theta err count", n_err - e0, 1);
    c0 = n_cmd;
    send_frame(C_S, 8'h00, 48'h0000_0000_0042, 8'h00, 0);
    repeat (4) @(negedge clk_i);
    chk("post-frame_err cmd_vld count", n_cmd - c0, 1);
    chk("post-frame_err theta", theta_o, 48'h0000_0000_0042);
    chk("post-frame_err burst_cnt", burst_cnt_o, 8'h01);
    chk("post-frame_err total err", n_err - e0, 1);

    // Reset mid-theta.
    e0 = n_err;
    send_byte(HDR);
    send_byte(C_B);
    send_byte(8'h09);
    send_byte(8'h77);
    @(negedge clk_i); rst_ni = 1'b0;
    #1;
    chk("mid-reset cmd_reg", cmd_reg_o, 0);
    chk("mid-reset burst_cnt", burst_cnt_o, 0);
    chk("mid-reset theta", theta_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("mid-reset no err", n_err - e0, 0);
    c0 = n_cmd;
    send_frame(C_S, 8'h00, 48'h0000_1234_5678, 8'h00, 0);
    repeat (4) @(negedge clk_i);
    chk("post-reset cmd_vld count", n_cmd - c0, 1);
    chk("post-reset cmd_reg", cmd_reg_o, C_S);
    chk("post-reset theta", theta_o, 48'h0000_1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
